// File: rtl/ssfpm_pack_n23.sv
// ssfpm_pack_n23 -- result back-end of the segmented approximate FP32
// multiplier (n23/m16 mantissa core).
//
// Normalizes the 26-bit approximate mantissa sum, optionally rounds, resolves
// special operands and exponent over/underflow, and packs an IEEE-754 single.
// Two-stage valid/ready pipeline: S1 holds the captured operand beat, S2
// holds the packed result until the consumer takes it. Latency 2, one beat
// per cycle while out_ready is high.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand beat handshake (in_ready is combinational)
//   sign_a/b, exp_a/b   operand signs and biased exponents
//   man_nz_a/b          operand fraction non-zero (NaN vs inf)
//   frac_sum[25:0]      approximate (Ma-1)+(Mb-1)+(Ma-1)(Mb-1), Q2.24
//   out_valid/out_ready result handshake
//   out_data[31:0]      packed FP32 result
//   out_flags[2:0]      {invalid, overflow, underflow}
//
// Build option: define SSFPM_PACK_RNE_EN for round-to-nearest-even;
// otherwise the fraction is truncated.

module ssfpm_pack_n23 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic        man_nz_a,
  input  logic        man_nz_b,
  input  logic [25:0] frac_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic accept, s2_load;

  assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // S2 takes S1 when empty or when its current result drains this cycle
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_load)        s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  // ---------------- S1 operand register ----------------
  logic        sa_q, sb_q, nza_q, nzb_q;
  logic [7:0]  ea_q, eb_q;
  logic [25:0] fs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      nza_q      <= 1'b0;
      nzb_q      <= 1'b0;
      ea_q       <= 8'd0;
      eb_q       <= 8'd0;
      fs_q       <= 26'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        sa_q  <= sign_a;
        sb_q  <= sign_b;
        nza_q <= man_nz_a;
        nzb_q <= man_nz_b;
        ea_q  <= exp_a;
        eb_q  <= exp_b;
        fs_q  <= frac_sum;
      end
    end
  end

  // ---------------- classification / normalize ----------------
  logic        sign_r;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [26:0] p_raw, p;
  logic        n;
  logic [22:0] frac_pre;
  logic signed [9:0] e_pre;

  assign sign_r = sa_q ^ sb_q;
  assign nan_a  = (ea_q == 8'hFF) &&  nza_q;
  assign nan_b  = (eb_q == 8'hFF) &&  nzb_q;
  assign inf_a  = (ea_q == 8'hFF) && !nza_q;
  assign inf_b  = (eb_q == 8'hFF) && !nzb_q;
  assign zero_a = (ea_q == 8'h00);
  assign zero_b = (eb_q == 8'h00);

  // P = 1.0 + frac_sum in Q3.24; anything at or above 4.0 saturates
  assign p_raw    = 27'h100_0000 + {1'b0, fs_q};
  assign p        = p_raw[26] ? 27'h3FF_FFFF : p_raw;
  assign n        = p[25];
  assign frac_pre = n ? p[24:2] : p[23:1];
  assign e_pre    = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q})
                  - 10'sd127 + $signed({9'd0, n});

  // ---------------- rounding ----------------
  logic        rc;
  logic [22:0] frac_r;

`ifdef SSFPM_PACK_RNE_EN
  logic guard, sticky, inc;
  assign guard  = n ? p[1] : p[0];
  assign sticky = n ? p[0] : 1'b0;
  assign inc    = guard && (sticky || frac_pre[0]);
  // carry-out leaves the fraction at zero and bumps the exponent
  assign {rc, frac_r} = {1'b0, frac_pre} + {23'd0, inc};
  logic unused_bits;
  assign unused_bits = p[26];
`else
  assign rc     = 1'b0;
  assign frac_r = frac_pre;
  logic unused_bits;
  assign unused_bits = ^{p[26], p[0]};
`endif

  logic signed [9:0] e_post;
  assign e_post = e_pre + $signed({9'd0, rc});

  // ---------------- special cases and pack ----------------
  logic [31:0] data_d;
  logic [2:0]  flags_d;

  always_comb begin
    data_d  = {sign_r, e_post[7:0], frac_r};
    flags_d = 3'b000;
    if (nan_a || nan_b) begin
      data_d  = QNAN;
      flags_d = 3'b100;
    end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
      data_d  = QNAN;
      flags_d = 3'b100;
    end else if (inf_a || inf_b) begin
      data_d  = {sign_r, 8'hFF, 23'd0};
    end else if (zero_a || zero_b) begin
      data_d  = {sign_r, 31'd0};
    end else if (e_post >= 10'sd255) begin
      data_d  = {sign_r, 8'hFF, 23'd0};
      flags_d = 3'b010;
    end else if (e_post <= 10'sd0) begin
      data_d  = {sign_r, 31'd0};
      flags_d = 3'b001;
    end
  end

  // ---------------- S2 result register ----------------
  logic [31:0] data_q;
  logic [2:0]  flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      data_q     <= 32'd0;
      flags_q    <= 3'd0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        data_q  <= data_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = data_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_ssfpm_pack_n23.sv
// Self-checking bench for ssfpm_pack_n23: directed corner vectors, backpressure,
// mid-stream reset, and randomized traffic against an arithmetic reference.
module tb_ssfpm_pack_n23;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        sign_a, sign_b, man_nz_a, man_nz_b;
  logic [7:0]  exp_a, exp_b;
  logic [25:0] frac_sum;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  ssfpm_pack_n23 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b),
    .exp_a(exp_a), .exp_b(exp_b),
    .man_nz_a(man_nz_a), .man_nz_b(man_nz_b),
    .frac_sum(frac_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];   // {flags, data} in acceptance order
  int accepts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued reasoning on integers, FP32 rules
  function automatic logic [34:0] model(input bit sa, input bit sb, input int ea,
                                        input int eb, input bit na, input bit nb,
                                        input int fs);
    bit s = sa ^ sb;
    int p, n, kept, drop, e, rc;
    logic [7:0] e8;
    rc = 0;
    if ((ea == 255 && na) || (eb == 255 && nb)) return {3'b100, 32'h7FC00000};
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {3'b100, 32'h7FC00000};
    if (ea == 255 || eb == 255) return {3'b000, s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0) return {3'b000, s, 31'd0};
    p = (1 << 24) + fs;
    if (p >= (1 << 26)) p = (1 << 26) - 1;
    n = (p >= (1 << 25)) ? 1 : 0;
    kept = (p >> (1 + n)) % (1 << 23);
    drop = p % (1 << (1 + n));
`ifdef SSFPM_PACK_RNE_EN
    if (drop > (1 << n) || (drop == (1 << n) && (kept % 2) == 1)) kept = kept + 1;
    if (kept == (1 << 23)) begin kept = 0; rc = 1; end
`else
    if (drop < 0) kept = 0;
`endif
    e = ea + eb - 127 + n + rc;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b001, s, 31'd0};
    e8 = e[7:0];
    return {3'b000, s, e8, kept[22:0]};
  endfunction

  // Output monitor: ordering, spurious results, stall stability
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_stable", 64'({out_flags, out_data}), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else chk("result", 64'({out_flags, out_data}), 64'(exp_q.pop_front()));
      end
      prev_stall <= out_valid && !out_ready;
      prev_out   <= {out_flags, out_data};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit sa, input bit sb, input logic [7:0] ea, input logic [7:0] eb,
                      input bit na, input bit nb, input logic [25:0] fs,
                      input bit use_model, input logic [34:0] ed, input bit rnd);
    bit ok = 0;
    sign_a = sa; sign_b = sb; exp_a = ea; exp_b = eb;
    man_nz_a = na; man_nz_b = nb; frac_sum = fs; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      accepts++;
      exp_q.push_back(use_model ? model(sa, sb, int'(ea), int'(eb), na, nb, int'(fs)) : ed);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    bit ok = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] held;
  logic [34:0] rne_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign_a = 0; sign_b = 0; exp_a = 0; exp_b = 0; man_nz_a = 0; man_nz_b = 0; frac_sum = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1.5 x 1.5 with latency check
    send(0, 0, 8'd127, 8'd127, 1, 1, 26'h1400000, 0, {3'b000, 32'h40100000}, 0);
    @(negedge clk); chk("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_edge2", 64'(out_valid), 64'd1);
    drain();

    send(0, 0, 8'd127, 8'd127, 0, 0, 26'd0, 0, {3'b000, 32'h3F800000}, 0);
    send(1, 0, 8'd127, 8'd127, 0, 0, 26'd0, 0, {3'b000, 32'hBF800000}, 0);
    send(0, 0, 8'd200, 8'd200, 0, 0, 26'd0, 0, {3'b010, 32'h7F800000}, 0);
    send(0, 0, 8'd10,  8'd10,  0, 0, 26'd0, 0, {3'b001, 32'h00000000}, 0);
    send(0, 0, 8'd255, 8'd127, 1, 0, 26'h3FFFFFF, 0, {3'b100, 32'h7FC00000}, 0);
    send(0, 0, 8'd255, 8'd0,   0, 0, 26'd5, 0, {3'b100, 32'h7FC00000}, 0);
    send(0, 1, 8'd255, 8'd128, 0, 0, 26'd0, 0, {3'b000, 32'hFF800000}, 0);
`ifdef SSFPM_PACK_RNE_EN
    rne_exp = {3'b000, 32'h3F800002};
`else
    rne_exp = {3'b000, 32'h3F800001};
`endif
    send(0, 0, 8'd127, 8'd127, 0, 0, 26'd3, 0, rne_exp, 0);
    drain();

    // Backpressure: 4 beats against a stalled consumer
    out_ready = 1'b0;
    accepts = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(k[0], 0, 8'd127, 8'(120 + k), 0, 0, 26'(k * 1000003), 1, 35'd0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        held = out_data;
        repeat (2) @(negedge clk);
        chk("bp_accepts", 64'(accepts), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold", 64'(out_data), 64'(held));
        @(posedge clk); #1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_b2b", 64'(out_valid), 64'd1);
        end
      end
    join
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(0, 0, 8'd130, 8'd120, 0, 0, 26'd77, 1, 35'd0, 0);
    send(1, 0, 8'd131, 8'd121, 0, 0, 26'd99, 1, 35'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1; rst = 1'b0; exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready1", 64'(in_ready), 64'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and idle gaps
    for (int k = 0; k < 400; k++) begin
      logic [7:0] ea, eb;
      int sel;
      sel = $urandom_range(0, 15);
      ea = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(1, 254));
      sel = $urandom_range(0, 15);
      eb = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(1, 254));
      send($urandom_range(0, 1), $urandom_range(0, 1), ea, eb,
           $urandom_range(0, 1), $urandom_range(0, 1), 26'($urandom),
           1, 35'd0, 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
